// File: rtl/wb_periph_mux_if.sv
// Host-side classic Wishbone bus used by wb_periph_mux.
// The slave modport is the mux's view; the master modport is the host's view.
interface wb_periph_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    input  wbs_we_i,
    input  wbs_sel_i,
    input  wbs_adr_i,
    input  wbs_dat_i,
    output wbs_ack_o,
    output wbs_dat_o
  );

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    output wbs_we_i,
    output wbs_sel_i,
    output wbs_adr_i,
    output wbs_dat_i,
    input  wbs_ack_o,
    input  wbs_dat_o
  );
endinterface

// File: rtl/wb_periph_mux.sv
// wb_periph_mux: Wishbone front-end that routes one host cycle at a time to
// the SPI or UART register bank, or to a local status CSR.
// Window offset map adr[9:8]: 0 SPI, 1 UART, 2 CSR, 3 unmapped.
// Optional feature macro WB_PERIPH_TIMEOUT_EN: when defined, a forwarded
// cycle that is not acked within TIMEOUT cycles is completed with 0xDEAD_BEEF
// and recorded in the CSR (sticky TO flag plus saturating TO count).
module wb_periph_mux #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  wb_periph_mux_if.slave     wbs,
  output logic [7:0]         s_adr_o,
  output logic [31:0]        s_dat_o,
  output logic               s_we_o,
  output logic [3:0]         s_sel_o,
  output logic               spi_stb_o,
  output logic               uart_stb_o,
  input  logic               spi_ack_i,
  input  logic               uart_ack_i,
  input  logic [31:0]        spi_dat_i,
  input  logic [31:0]        uart_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  localparam logic [1:0]  REG_SPI  = 2'd0;
  localparam logic [1:0]  REG_UART = 2'd1;
  localparam logic [1:0]  REG_CSR  = 2'd2;
  localparam logic [15:0] CSR_ID   = 16'hA5C1;
  localparam logic [31:0] TO_DATA  = 32'hDEAD_BEEF;

  // Reject timeout values the 16-bit timer cannot represent.
  if ((TIMEOUT < 32'd2) || (TIMEOUT > 32'd65535)) begin : g_bad_timeout
    $error("wb_periph_mux: TIMEOUT must be within 2..65535");
  end

  // Status word as seen by a host read of the CSR.
  function automatic logic [31:0] csr_word(
    input logic       unm,
    input logic       to_flag,
    input logic [7:0] to_cnt
  );
    csr_word = {CSR_ID, 6'd0, unm, to_flag, to_cnt};
  endfunction

  state_e      state_q, state_d;
  logic        spi_stb_q, spi_stb_d;
  logic        uart_stb_q, uart_stb_d;
  logic [7:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        unm_flag_q, unm_flag_d;

  logic        req_hit_s;
  logic        tgt_ack_s;
  logic [31:0] tgt_dat_s;
  logic [31:0] csr_rd_s;

`ifdef WB_PERIPH_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

  logic [15:0] timer_q, timer_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic        to_flag_q, to_flag_d;
`endif

  // Request decode, target response select and CSR read value.
  always_comb begin
    req_hit_s = wbs.wbs_cyc_i && wbs.wbs_stb_i &&
                (wbs.wbs_adr_i[31:10] == ADDR_BASE[31:10]);
    // Only one strobe is ever high, so the strobe identifies the target.
    tgt_ack_s = spi_stb_q ? spi_ack_i : uart_ack_i;
    tgt_dat_s = spi_stb_q ? spi_dat_i : uart_dat_i;
`ifdef WB_PERIPH_TIMEOUT_EN
    csr_rd_s  = csr_word(unm_flag_q, to_flag_q, to_cnt_q);
`else
    csr_rd_s  = csr_word(unm_flag_q, 1'b0, 8'd0);
`endif
  end

  // Next-state and next-output logic of the IDLE/FWD/ACK controller.
  always_comb begin
    state_d    = state_q;
    spi_stb_d  = spi_stb_q;
    uart_stb_d = uart_stb_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    unm_flag_d = unm_flag_q;
`ifdef WB_PERIPH_TIMEOUT_EN
    timer_d    = timer_q;
    to_cnt_d   = to_cnt_q;
    to_flag_d  = to_flag_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_hit_s) begin
          adr_d = wbs.wbs_adr_i[7:0];
          dat_d = wbs.wbs_dat_i;
          we_d  = wbs.wbs_we_i;
          sel_d = wbs.wbs_sel_i;
          case (wbs.wbs_adr_i[9:8])
            REG_SPI: begin
              spi_stb_d = 1'b1;
              state_d   = ST_FWD;
`ifdef WB_PERIPH_TIMEOUT_EN
              timer_d   = 16'd0;
`endif
            end
            REG_UART: begin
              uart_stb_d = 1'b1;
              state_d    = ST_FWD;
`ifdef WB_PERIPH_TIMEOUT_EN
              timer_d    = 16'd0;
`endif
            end
            REG_CSR: begin
              // Writes return zero data; reads return the current status.
              rdata_d    = wbs.wbs_we_i ? 32'd0 : csr_rd_s;
              unm_flag_d = (wbs.wbs_we_i && wbs.wbs_sel_i[1] && wbs.wbs_dat_i[9]) ?
                           1'b0 : unm_flag_q;
`ifdef WB_PERIPH_TIMEOUT_EN
              to_cnt_d   = (wbs.wbs_we_i && wbs.wbs_sel_i[0]) ? 8'd0 : to_cnt_q;
              to_flag_d  = (wbs.wbs_we_i && wbs.wbs_sel_i[1] && wbs.wbs_dat_i[8]) ?
                           1'b0 : to_flag_q;
`endif
              ack_d      = 1'b1;
              state_d    = ST_ACK;
            end
            default: begin
              rdata_d    = 32'd0;
              unm_flag_d = 1'b1;
              ack_d      = 1'b1;
              state_d    = ST_ACK;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FWD: begin
        if (!wbs.wbs_cyc_i) begin
          // Host abandoned the cycle: release the slave quietly.
          spi_stb_d  = 1'b0;
          uart_stb_d = 1'b0;
          state_d    = ST_IDLE;
        end else if (tgt_ack_s) begin
          // A real ack beats a coincident timer expiry.
          rdata_d    = we_q ? 32'd0 : tgt_dat_s;
          spi_stb_d  = 1'b0;
          uart_stb_d = 1'b0;
          ack_d      = 1'b1;
          state_d    = ST_ACK;
        end
`ifdef WB_PERIPH_TIMEOUT_EN
        else if (timer_q == TO_LAST) begin
          rdata_d    = TO_DATA;
          spi_stb_d  = 1'b0;
          uart_stb_d = 1'b0;
          to_flag_d  = 1'b1;
          to_cnt_d   = (to_cnt_q == 8'hFF) ? 8'hFF : (to_cnt_q + 8'd1);
          ack_d      = 1'b1;
          state_d    = ST_ACK;
        end else begin
          timer_d = timer_q + 16'd1;
        end
`else
        else begin
          state_d = ST_FWD;
        end
`endif
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        spi_stb_d  = 1'b0;
        uart_stb_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Controller state, latched bus and host response registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      spi_stb_q  <= 1'b0;
      uart_stb_q <= 1'b0;
      adr_q      <= 8'd0;
      dat_q      <= 32'd0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      ack_q      <= 1'b0;
      rdata_q    <= 32'd0;
      unm_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      spi_stb_q  <= spi_stb_d;
      uart_stb_q <= uart_stb_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      unm_flag_q <= unm_flag_d;
    end
  end

`ifdef WB_PERIPH_TIMEOUT_EN
  // Response timer and timeout bookkeeping registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      timer_q   <= 16'd0;
      to_cnt_q  <= 8'd0;
      to_flag_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end
`endif

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdata_q;
  assign s_adr_o       = adr_q;
  assign s_dat_o       = dat_q;
  assign s_we_o        = we_q;
  assign s_sel_o       = sel_q;
  assign spi_stb_o     = spi_stb_q;
  assign uart_stb_o    = uart_stb_q;

endmodule

// File: tb/tb_wb_periph_mux.sv
// Self-checking bench for wb_periph_mux: directed scenarios plus randomized
// traffic against a transaction-level model of the status CSR.
module tb_wb_periph_mux;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          TMO    = 8;
  localparam int          BUDGET = 20;
`ifdef WB_PERIPH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_periph_mux_if bus();

  logic [7:0]  s_adr;
  logic [31:0] s_dat;
  logic        s_we;
  logic [3:0]  s_sel;
  logic        spi_stb, uart_stb;
  logic        spi_ack, uart_ack;
  logic [31:0] spi_rd, uart_rd;

  wb_periph_mux #(.ADDR_BASE(BASE), .TIMEOUT(TMO)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs       (bus),
    .s_adr_o   (s_adr),
    .s_dat_o   (s_dat),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .spi_stb_o (spi_stb),
    .uart_stb_o(uart_stb),
    .spi_ack_i (spi_ack),
    .uart_ack_i(uart_ack),
    .spi_dat_i (spi_rd),
    .uart_dat_i(uart_rd)
  );

  int checks = 0;
  int errors = 0;

  // Slave models: ack in the Nth strobed cycle (0 = never), or forced ack.
  int   spi_dly = 0, uart_dly = 0;
  int   spi_cnt = 0, uart_cnt = 0;
  logic spi_force = 1'b0, uart_force = 1'b0;

  always @(negedge clk) begin
    int n;
    n = spi_stb ? spi_cnt + 1 : 0;
    spi_cnt <= n;
    spi_ack <= spi_force | (spi_stb && (spi_dly != 0) && (n == spi_dly));
  end

  always @(negedge clk) begin
    int n;
    n = uart_stb ? uart_cnt + 1 : 0;
    uart_cnt <= n;
    uart_ack <= uart_force | (uart_stb && (uart_dly != 0) && (n == uart_dly));
  end

  // Reference model of the CSR state.
  int   m_cnt = 0;
  logic m_to = 1'b0, m_unm = 1'b0;

  function automatic logic [31:0] csr_model();
    logic [31:0] v;
    v = {16'hA5C1, 6'd0, m_unm, 9'd0};
    if (TO_EN) v[8:0] = {m_to, m_cnt[7:0]};
    return v;
  endfunction

  function automatic void model_csr_write(input logic [3:0] sel, input logic [31:0] d);
    if (sel[0]) m_cnt = 0;
    if (sel[1] && d[8]) m_to = 1'b0;
    if (sel[1] && d[9]) m_unm = 1'b0;
  endfunction

  // Results of the last host transfer.
  logic        r_acked, r_we, r_tail;
  int          r_lat, r_spi, r_uart;
  logic [31:0] r_data, r_dat;
  logic [7:0]  r_adr;
  logic [3:0]  r_sel;

  // One host cycle, started just after a falling edge. Drops the request on
  // ack or when the cycle budget runs out, then observes one quiet cycle.
  task automatic host_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int budget);
    r_acked = 1'b0; r_lat = 0; r_data = 32'd0; r_spi = 0; r_uart = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
    for (int k = 1; k <= budget && !r_acked; k++) begin
      @(negedge clk);
      if (k == 1) begin
        r_adr = s_adr; r_dat = s_dat; r_we = s_we; r_sel = s_sel;
      end
      if (spi_stb)  r_spi++;
      if (uart_stb) r_uart++;
      if (bus.wbs_ack_o) begin
        r_acked = 1'b1; r_lat = k; r_data = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    r_tail = spi_stb | uart_stb | bus.wbs_ack_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'd0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    spi_rd = 32'd0; uart_rd = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.wbs_ack_o, bus.wbs_dat_o, s_adr, s_dat, s_we, s_sel, spi_stb, uart_stb} !== 80'd0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b dat=%h s_adr=%h s_dat=%h we=%b sel=%h stb=%b%b expected all 0",
               bus.wbs_ack_o, bus.wbs_dat_o, s_adr, s_dat, s_we, s_sel, spi_stb, uart_stb);
    end
    rst = 1'b0;
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (!r_acked || r_data !== 32'hA5C1_0000) begin
      errors++;
      $display("FAIL reset_csr acked=%b data=%h expected ack with a5c10000", r_acked, r_data);
    end
  endtask

  task automatic test_spi_write();
    spi_dly = 3; uart_force = 1'b1;
    host_xfer(BASE + 32'h004, 1'b1, 4'hF, 32'h1234_5678, BUDGET);
    uart_force = 1'b0;
    checks++;
    if (!r_acked || r_lat !== 4 || r_spi !== 3 || r_uart !== 0 || r_tail !== 1'b0) begin
      errors++;
      $display("FAIL spi_write_timing acked=%b lat=%0d spi=%0d uart=%0d tail=%b expected 1/4/3/0/0",
               r_acked, r_lat, r_spi, r_uart, r_tail);
    end
    checks++;
    if (r_adr !== 8'h04 || r_dat !== 32'h1234_5678 || r_we !== 1'b1 || r_sel !== 4'hF || r_data !== 32'd0) begin
      errors++;
      $display("FAIL spi_write_bus adr=%h dat=%h we=%b sel=%h rdata=%h expected 04/12345678/1/f/0",
               r_adr, r_dat, r_we, r_sel, r_data);
    end
  endtask

  task automatic test_uart_read();
    uart_dly = 1; uart_rd = 32'hCAFE_0001;
    host_xfer(BASE + 32'h108, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (!r_acked || r_lat !== 2 || r_data !== 32'hCAFE_0001 || r_adr !== 8'h08 || r_uart !== 1 || r_spi !== 0) begin
      errors++;
      $display("FAIL uart_read acked=%b lat=%0d data=%h adr=%h uart=%0d spi=%0d expected 1/2/cafe0001/08/1/0",
               r_acked, r_lat, r_data, r_adr, r_uart, r_spi);
    end
  endtask

  task automatic test_unmapped_csr();
    bus.wbs_dat_i = 32'hFFFF_FFFF;
    host_xfer(BASE + 32'h300, 1'b0, 4'hF, 32'h0, BUDGET);
    m_unm = 1'b1;
    checks++;
    if (!r_acked || r_lat !== 1 || r_data !== 32'd0) begin
      errors++;
      $display("FAIL unmapped_read acked=%b lat=%0d data=%h expected 1/1/0", r_acked, r_lat, r_data);
    end
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (!r_acked || r_lat !== 1 || r_data !== 32'hA5C1_0200) begin
      errors++;
      $display("FAIL csr_unm_set acked=%b lat=%0d data=%h expected 1/1/a5c10200", r_acked, r_lat, r_data);
    end
    host_xfer(BASE + 32'h200, 1'b1, 4'b0010, 32'h0000_0200, BUDGET);
    model_csr_write(4'b0010, 32'h0000_0200);
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== 32'hA5C1_0000) begin
      errors++;
      $display("FAIL csr_unm_clear data=%h expected a5c10000", r_data);
    end
  endtask

  task automatic test_timeout();
    spi_dly = 0;
    host_xfer(BASE + 32'h200, 1'b1, 4'b0011, 32'h0000_0300, BUDGET);
    model_csr_write(4'b0011, 32'h0000_0300);
`ifdef WB_PERIPH_TIMEOUT_EN
    host_xfer(BASE + 32'h010, 1'b0, 4'hF, 32'd0, BUDGET);
    m_to = 1'b1; m_cnt = 1;
    checks++;
    if (!r_acked || r_lat !== TMO + 1 || r_data !== 32'hDEAD_BEEF || r_spi !== TMO || r_tail !== 1'b0) begin
      errors++;
      $display("FAIL timeout_ack acked=%b lat=%0d data=%h spi=%0d tail=%b expected 1/%0d/deadbeef/%0d/0",
               r_acked, r_lat, r_data, r_spi, r_tail, TMO + 1, TMO);
    end
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== 32'hA5C1_0101) begin
      errors++;
      $display("FAIL timeout_csr data=%h expected a5c10101", r_data);
    end
    for (int i = 0; i < 299; i++) begin
      host_xfer(BASE + 32'h010, 1'b0, 4'hF, 32'd0, BUDGET);
      if (m_cnt < 255) m_cnt++;
      checks++;
      if (r_lat !== TMO + 1 || r_data !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL timeout_repeat_%0d lat=%0d data=%h expected %0d/deadbeef", i, r_lat, r_data, TMO + 1);
      end
    end
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== 32'hA5C1_01FF || r_data !== csr_model()) begin
      errors++;
      $display("FAIL timeout_saturate data=%h expected a5c101ff", r_data);
    end
`else
    host_xfer(BASE + 32'h010, 1'b0, 4'hF, 32'd0, 40);
    checks++;
    if (r_acked !== 1'b0 || r_spi !== 40 || r_tail !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout acked=%b spi=%0d tail=%b expected 0/40/0", r_acked, r_spi, r_tail);
    end
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== csr_model()) begin
      errors++;
      $display("FAIL no_timeout_csr data=%h expected %h", r_data, csr_model());
    end
`endif
  endtask

  task automatic test_abort();
    spi_dly = 0;
    host_xfer(BASE + 32'h020, 1'b0, 4'hF, 32'd0, 2);
    checks++;
    if (r_acked !== 1'b0 || r_spi !== 2 || r_tail !== 1'b0) begin
      errors++;
      $display("FAIL abort acked=%b spi=%0d tail=%b expected 0/2/0", r_acked, r_spi, r_tail);
    end
    spi_dly = 2; spi_rd = 32'h0BAD_F00D;
    host_xfer(BASE + 32'h024, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (!r_acked || r_lat !== 3 || r_data !== 32'h0BAD_F00D || r_adr !== 8'h24) begin
      errors++;
      $display("FAIL after_abort acked=%b lat=%0d data=%h adr=%h expected 1/3/0badf00d/24",
               r_acked, r_lat, r_data, r_adr);
    end
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== csr_model()) begin
      errors++;
      $display("FAIL abort_no_flags data=%h expected %h", r_data, csr_model());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic seen;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h200;
    seen = 1'b0;
    for (k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = bus.wbs_ack_o;
    end
    checks++;
    if (!seen || bus.wbs_dat_o !== csr_model()) begin
      errors++;
      $display("FAIL b2b_first seen=%b data=%h expected ack with %h", seen, bus.wbs_dat_o, csr_model());
    end
    bus.wbs_adr_i = BASE + 32'h300;
    @(negedge clk);
    checks++;
    if (bus.wbs_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap ack=%b expected 0", bus.wbs_ack_o);
    end
    @(negedge clk);
    checks++;
    if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== 32'd0) begin
      errors++;
      $display("FAIL b2b_second ack=%b data=%h expected 1/0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    m_unm = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int          kind, d, exp_lat, exp_spi, exp_uart, stb_cyc;
      logic [31:0] adr, dat, rd, exp_dat;
      logic        we, exp_ack, chk_dat;
      logic [3:0]  sel;
      kind = $urandom_range(0, 5);
      d    = $urandom_range(0, 11);
      dat  = $urandom; rd = $urandom;
      we   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      adr  = {BASE[31:10], 2'(kind), 8'($urandom_range(0, 255))};
      if (kind == 2) we = 1'b0;
      if (kind == 5) begin adr[9:8] = 2'd2; we = 1'b1; end
      if (kind == 4) adr[31:10] = BASE[31:10] ^ 22'($urandom_range(1, 4194303));
      spi_dly = d; uart_dly = d; spi_rd = rd; uart_rd = rd;
      exp_ack = 1'b1; exp_lat = 1; exp_dat = 32'd0; chk_dat = 1'b1;
      exp_spi = 0; exp_uart = 0; stb_cyc = 0;
      case (kind)
        0, 1: begin
          if (d != 0 && (!TO_EN || d <= TMO)) begin
            exp_lat = d + 1; exp_dat = we ? 32'd0 : rd; stb_cyc = d;
          end else if (TO_EN) begin
            exp_lat = TMO + 1; exp_dat = 32'hDEAD_BEEF; stb_cyc = TMO;
            m_to = 1'b1; if (m_cnt < 255) m_cnt++;
          end else begin
            exp_ack = 1'b0; stb_cyc = BUDGET;
          end
          if (kind == 0) exp_spi = stb_cyc; else exp_uart = stb_cyc;
        end
        2: exp_dat = csr_model();
        3: m_unm = 1'b1;
        4: exp_ack = 1'b0;
        default: begin chk_dat = 1'b0; model_csr_write(sel, dat); end
      endcase
      host_xfer(adr, we, sel, dat, BUDGET);
      checks++;
      if (r_acked !== exp_ack || (exp_ack && r_lat !== exp_lat) || (exp_ack && chk_dat && r_data !== exp_dat) ||
          r_spi !== exp_spi || r_uart !== exp_uart || r_tail !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d kind=%0d d=%0d got ack=%b lat=%0d data=%h spi=%0d uart=%0d tail=%b expected ack=%b lat=%0d data=%h spi=%0d uart=%0d",
                 i, kind, d, r_acked, r_lat, r_data, r_spi, r_uart, r_tail, exp_ack, exp_lat, exp_dat, exp_spi, exp_uart);
      end
      if (kind != 4) begin
        checks++;
        if (r_adr !== adr[7:0] || r_dat !== dat || r_we !== we || r_sel !== sel) begin
          errors++;
          $display("FAIL rand_bus_%0d adr=%h dat=%h we=%b sel=%h expected %h/%h/%b/%h",
                   i, r_adr, r_dat, r_we, r_sel, adr[7:0], dat, we, sel);
        end
      end
    end
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== csr_model()) begin
      errors++;
      $display("FAIL rand_csr data=%h expected %h", r_data, csr_model());
    end
  endtask

  task automatic test_reset_mid();
    spi_dly = 1; spi_rd = 32'h5A5A_0F0F;
    host_xfer(BASE + 32'h0FC, 1'b0, 4'hF, 32'h7777_7777, BUDGET);
    spi_dly = 0;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = BASE + 32'h044; bus.wbs_dat_i = 32'h1357_9BDF;
    repeat (2) @(negedge clk);
    checks++;
    if (spi_stb !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fwd spi_stb=%b expected 1", spi_stb);
    end
    rst = 1'b1; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.wbs_ack_o, bus.wbs_dat_o, s_adr, s_dat, s_we, s_sel, spi_stb, uart_stb} !== 80'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs ack=%b dat=%h s_adr=%h s_dat=%h we=%b sel=%h stb=%b%b expected all 0",
               bus.wbs_ack_o, bus.wbs_dat_o, s_adr, s_dat, s_we, s_sel, spi_stb, uart_stb);
    end
    rst = 1'b0; m_cnt = 0; m_to = 1'b0; m_unm = 1'b0;
    spi_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.wbs_ack_o !== 1'b0 || spi_stb !== 1'b0) begin
        errors++;
        $display("FAIL late_ack_%0d ack=%b spi_stb=%b expected 0/0", i, bus.wbs_ack_o, spi_stb);
      end
    end
    spi_force = 1'b0;
    @(negedge clk);
    host_xfer(BASE + 32'h200, 1'b0, 4'hF, 32'd0, BUDGET);
    checks++;
    if (r_data !== 32'hA5C1_0000) begin
      errors++;
      $display("FAIL reset_mid_csr data=%h expected a5c10000", r_data);
    end
  endtask

  initial begin
    test_reset();
    test_spi_write();
    test_uart_read();
    test_unmapped_csr();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_periph_mux.md
# wb_periph_mux

Wishbone slave front-end that sits between the management SoC Wishbone port and the user-area SPI and UART peripheral register banks. It decodes each classic Wishbone cycle onto exactly one downstream slave, serialises access so only one peripheral is strobed at a time, and returns the response to the host. It also enforces a bounded response time via a per-cycle timeout and exposes a small status CSR.

## Interface
Parameters:
- ADDR_BASE, 32'h3000_0000, window base; decoded on wbs_adr_i[31:10]
- TIMEOUT, 255, cycles allowed for a downstream ack, legal 2..65535

Ports:
- wb_clk_i  in  1  single clock, all logic rising-edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  host cycle/strobe/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  host address/write data
- wbs_ack_o  out  1  host ack, registered
- wbs_dat_o  out  32  host read data, registered
- s_adr_o  out  8  latched word offset adr[7:0] to both slaves
- s_dat_o  out  32  latched write data; s_we_o out 1; s_sel_o out 4
- spi_stb_o, uart_stb_o  out  1 each  per-slave strobe (cyc implied)
- spi_ack_i, uart_ack_i  in  1 each  slave acks
- spi_dat_i, uart_dat_i  in  32 each  slave read data

## Operation
- Offset map (adr[9:8]): 0 SPI, 1 UART, 2 CSR, 3 unmapped. Addresses outside the window are ignored: no ack, state stays IDLE.
- FSM states: IDLE, FWD, ACK.
- IDLE: on cyc&stb in window, latch adr/dat/we/sel. SPI/UART target: go FWD and set that slave's stb. CSR: perform access and go ACK. Unmapped: rdata=0, set UNM flag, go ACK.
- FWD: hold the target stb and the latched bus.
  - Target ack: capture its data (writes capture 0), clear stb, go ACK.
  - Timer reaches TIMEOUT-1 without ack: clear stb, rdata=32'hDEAD_BEEF, set TO flag, increment TO count (saturates at 255), go ACK.
  - The non-target slave's ack is ignored.
- ACK: wbs_ack_o=1 for exactly one cycle, then go IDLE.
- Abort: cyc_i low in FWD clears stb and returns to IDLE with no ack. The abort does not set flags.
- CSR read layout: [7:0] TO count, [8] TO sticky, [9] UNM sticky, [15:10] 0, [31:16] 16'hA5C1.
- CSR writes: sel[0] clears the count. sel[1] is write-1-to-clear for bits 8/9. Other bytes are ignored.
- Simultaneous timeout expiry and ack in the same cycle: the ack wins and no flag is set.
- Reset values: stbs=0, wbs_ack_o=0, wbs_dat_o=0, s_* outputs=0, flags=0, count=0, FSM=IDLE.
- A mid-operation reset returns the FSM to IDLE on the next edge, with no ack issued.

## Timing
- CSR or unmapped access: stb sampled at edge 0 -> wbs_ack_o high in cycle 1.
- Forwarded access: stb sampled at edge 0 -> slave stb high from cycle 1. Slave ack sampled at edge n -> wbs_ack_o high in cycle n+1 and slave stb low in cycle n+1.
- Minimum forwarded latency is 2 cycles from request to ack.
- The timer starts at 0 in the first FWD cycle. Timeout ack is high in cycle TIMEOUT+1 after the request.
- wbs_dat_o is valid only while ack=1 and holds its last value otherwise.
- One outstanding cycle only. A new request is accepted no earlier than the cycle after ack, when it is sampled in IDLE.

## Configuration
- WB_PERIPH_TIMEOUT_EN defined: the timer, TO flag and TO count are present as specified above.
- WB_PERIPH_TIMEOUT_EN undefined: FWD waits indefinitely for the ack or an abort. CSR bits [8:0] read 0, and writes to them are ignored.

## Test plan
- SPI write to ADDR_BASE+0x004, data 0x1234_5678, slave acks after 3 cycles -> spi_stb_o high for 3 cycles, s_adr_o=0x04, uart_stb_o stays 0, one wbs_ack_o pulse.
- UART read at +0x108, slave returns 0xCAFE_0001 with an immediate ack -> wbs_dat_o=0xCAFE_0001 with ack, 2-cycle latency.
- Read at +0x300 then CSR read at +0x200 -> first read returns 0; CSR reads 0xA5C1_0200. Write 0x200 to CSR with sel=4'b0010 -> CSR reads 0xA5C1_0000.
- SPI slave never acks, TIMEOUT=8, macro defined -> ack in cycle 9 with 0xDEAD_BEEF; CSR reads 0xA5C1_0101. Repeat 300 times -> count saturates at 0xFF.
- Drop cyc_i in the second FWD cycle -> stb drops next cycle, no ack, FSM in IDLE; the next SPI access completes normally.
- Assert wb_rst_i during FWD -> all outputs 0 on the next edge. A late slave ack after reset produces no host ack.
